// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM stage sitting between the EX/MEM and MEM/WB registers.
// ALU results pass straight through; loads and stores are executed one byte
// at a time over a byte-wide memory port, with a stall request held upstream
// until the access completes.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, misaligned
// halfword/word accesses are dropped as bubbles instead of being transferred.
module mem_stage #(
    parameter int         XLEN    = 32,
    parameter logic [4:0] NOP_REG = 5'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [3:0]      mem_op_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_sdata_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_a_o,
    output logic [7:0]      mem_dout_o,
    input  logic [7:0]      mem_din_i,
    input  logic            mem_ack_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stall_req_o
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Index of the final byte of an access (access size minus one).
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [3:0] op, input logic [XLEN-1:0] m);
        case (op)
            OP_LB:   return {{(XLEN-8){m[7]}}, m[7:0]};
            OP_LH:   return {{(XLEN-16){m[15]}}, m[15:0]};
            OP_LBU:  return {{(XLEN-8){1'b0}}, m[7:0]};
            OP_LHU:  return {{(XLEN-16){1'b0}}, m[15:0]};
            default: return m;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d, count_inc;
    logic [3:0]      op_q, op_d;
    logic [4:0]      lat_wd_q, lat_wd_d;
    logic [XLEN-1:0] addr_q, addr_d, sdata_q, sdata_d, data_q, data_d, merged;
    logic [4:0]      idx_cur, idx_next;
    logic [4:0]      wd_d;
    logic            wreg_d, req_d, we_d;
    logic [XLEN-1:0] wdata_d, a_d;
    logic [7:0]      dout_d;
    logic            misaligned, start;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((mem_op_i == OP_LH || mem_op_i == OP_LHU || mem_op_i == OP_SH) && mem_addr_i[0])
                     || ((mem_op_i == OP_LW || mem_op_i == OP_SW) && (mem_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign start       = (state_q == IDLE) && valid_i && (is_load(mem_op_i) || is_store(mem_op_i)) && !misaligned;
    assign stall_req_o = start || (state_q == XFER);

    assign count_inc = count_q + 2'd1;
    assign idx_cur   = {count_q, 3'b000};
    assign idx_next  = {count_inc, 3'b000};

    // Control state and all registered port outputs, cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            wd_o       <= NOP_REG;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_a_o    <= '0;
            mem_dout_o <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wd_o       <= wd_d;
            wreg_o     <= wreg_d;
            wdata_o    <= wdata_d;
            mem_req_o  <= req_d;
            mem_we_o   <= we_d;
            mem_a_o    <= a_d;
            mem_dout_o <= dout_d;
        end
    end

    // Captured instruction fields and load assembly buffer.
    // NOTE: these are only read after being loaded on acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        lat_wd_q <= lat_wd_d;
        addr_q   <= addr_d;
        sdata_q  <= sdata_d;
        data_q   <= data_d;
    end

    // Next-state logic: accept, transfer bytes until the last ack, then one result cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = XFER;
            XFER:    if (mem_ack_i && (count_q == last_idx(op_q))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and captured fields.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        lat_wd_d = lat_wd_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        data_d   = data_q;
        wd_d     = NOP_REG;
        wreg_d   = 1'b0;
        wdata_d  = '0;
        req_d    = 1'b0;
        we_d     = 1'b0;
        a_d      = '0;
        dout_d   = 8'h00;
        merged   = data_q;
        merged[idx_cur +: 8] = mem_din_i;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = mem_op_i;
                    lat_wd_d = wd_i;
                    addr_d   = mem_addr_i;
                    sdata_d  = mem_sdata_i;
                    data_d   = '0;
                    count_d  = 2'd0;
                    req_d    = 1'b1;
                    we_d     = is_store(mem_op_i);
                    a_d      = mem_addr_i;
                    dout_d   = mem_sdata_i[7:0];
                end else if (valid_i && !is_load(mem_op_i) && !is_store(mem_op_i)) begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end
            end
            XFER: begin
                if (mem_ack_i) begin
                    data_d = merged;
                    if (count_q == last_idx(op_q)) begin
                        if (is_load(op_q)) begin
                            wreg_d  = 1'b1;
                            wd_d    = lat_wd_q;
                            wdata_d = extend(op_q, merged);
                        end
                    end else begin
                        count_d = count_inc;
                        req_d   = 1'b1;
                        we_d    = mem_we_o;
                        a_d     = addr_q + XLEN'(count_inc);
                        dout_d  = sdata_q[idx_next +: 8];
                    end
                end else begin
                    req_d  = 1'b1;
                    we_d   = mem_we_o;
                    a_d    = mem_a_o;
                    dout_d = mem_dout_o;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of instructions with hand-computed results,
// a byte memory responder with programmable wait states, and scoreboard
// queues for expected port transfers and MEM/WB results.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i;
    logic        mem_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;

    mem_stage #(.XLEN(32), .NOP_REG(5'd0)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_sdata_i(mem_sdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i),
        .mem_ack_i(mem_ack_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          wait_n;
        logic        exp_stall;
        int          exp_lat;
        logic [4:0]  exp_wd;
        logic        exp_wreg;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [7:0]  dout;
    } port_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } res_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs[$];
    port_t       port_q[$];
    res_t        res_q[$];
    logic [7:0]  mem_model [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic valid, input logic [3:0] op,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic [31:0] addr, input logic [31:0] sdata, input int wait_n,
                                input logic exp_stall, input int exp_lat, input logic [4:0] exp_wd,
                                input logic exp_wreg, input logic [31:0] exp_wdata);
        vec_t v;
        v.name = name; v.valid = valid; v.op = op; v.wd = wd; v.wreg = wreg;
        v.wdata = wdata; v.addr = addr; v.sdata = sdata; v.wait_n = wait_n;
        v.exp_stall = exp_stall; v.exp_lat = exp_lat; v.exp_wd = exp_wd;
        v.exp_wreg = exp_wreg; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Number of bytes the stage should move on the port for an instruction.
    function automatic int exp_nbytes(input logic valid, input logic [3:0] op, input logic [31:0] addr);
        int n;
        if (!valid) return 0;
        case (op)
            4'd1, 4'd4, 4'd6: n = 1;
            4'd2, 4'd5, 4'd7: n = 2;
            4'd3, 4'd8:       n = 4;
            default:          n = 0;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        if (n == 2 && addr[0]) n = 0;
        if (n == 4 && addr[1:0] != 2'b00) n = 0;
`endif
        return n;
    endfunction

    // Answer the current request: compare it against the expected transfer,
    // and ack it once the programmed number of wait cycles has elapsed.
    task automatic service(input string name, input int wait_n, inout int wcnt);
        port_t p;
        if (port_q.size() == 0) begin
            check({name, "/unexpected_req"}, 32'(mem_req_o), 32'd0);
            return;
        end
        p = port_q[0];
        check({name, "/port_a"}, mem_a_o, p.a);
        check({name, "/port_we"}, 32'(mem_we_o), 32'(p.we));
        if (p.we) check({name, "/port_dout"}, 32'(mem_dout_o), 32'(p.dout));
        check({name, "/busy_wreg"}, 32'(wreg_o), 32'd0);
        if (wcnt == wait_n) begin
            mem_ack_i = 1'b1;
            mem_din_i = mem_model.exists(mem_a_o) ? mem_model[mem_a_o] : 8'h00;
            if (mem_we_o) mem_model[mem_a_o] = mem_dout_o;
            void'(port_q.pop_front());
            wcnt = 0;
        end else begin
            wcnt++;
        end
    endtask

    task automatic compare_result(input string name);
        res_t r;
        r = res_q.pop_front();
        check({name, "/wd"}, 32'(wd_o), 32'(r.wd));
        check({name, "/wreg"}, 32'(wreg_o), 32'(r.wreg));
        if (r.wreg) check({name, "/wdata"}, wdata_o, r.wdata);
    endtask

    // Present one instruction (called just after a rising edge) and follow it
    // to its MEM/WB result; returns just after a rising edge.
    task automatic run(input vec_t v);
        port_t p;
        res_t  r;
        int    n, cyc, wcnt;
        n = exp_nbytes(v.valid, v.op, v.addr);
        for (int i = 0; i < n; i++) begin
            p.a    = v.addr + 32'(i);
            p.we   = (v.op >= 4'd6) && (v.op <= 4'd8);
            p.dout = v.sdata[8*i +: 8];
            port_q.push_back(p);
        end
        r.wd = v.exp_wd; r.wreg = v.exp_wreg; r.wdata = v.exp_wdata;
        res_q.push_back(r);

        valid_i = v.valid; mem_op_i = v.op; wd_i = v.wd; wreg_i = v.wreg;
        wdata_i = v.wdata; mem_addr_i = v.addr; mem_sdata_i = v.sdata;

        cyc = 0; wcnt = 0;
        while (1) begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (cyc == 0) check({v.name, "/stall"}, 32'(stall_req_o), 32'(v.exp_stall));
            if (mem_req_o) service(v.name, v.wait_n, wcnt);
            if (!stall_req_o) break;
            cyc++;
            if (cyc > 200) begin
                check({v.name, "/timeout"}, 32'd1, 32'd0);
                break;
            end
        end

        if (cyc > 0) begin
            compare_result(v.name);
            @(posedge clk); #1;
            valid_i = 1'b0;
        end else begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_req_o) service(v.name, v.wait_n, wcnt);
            compare_result(v.name);
            cyc = 1;
            @(posedge clk); #1;
        end
        check({v.name, "/latency"}, 32'(cyc), 32'(v.exp_lat));
        check({v.name, "/xfers_left"}, 32'(port_q.size()), 32'd0);
        port_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        mem_op_i = 4'd0; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
        mem_din_i = 8'h00; mem_ack_i = 1'b0;

        mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
        mem_model[32'h104] = 8'h9A; mem_model[32'h20]  = 8'h80;

        //               name       vld op    wd     wr  wdata         addr          sdata         wt stl lat wd_e   wr_e exp_wdata
        vecs.push_back(mk("alu",     1, 4'd0, 5'd5,  1, 32'h7,        32'h0,        32'h0,        0, 0, 1, 5'd5,  1, 32'h7));
        vecs.push_back(mk("lw",      1, 4'd3, 5'd10, 1, 32'h0,        32'h100,      32'h0,        0, 1, 5, 5'd10, 1, 32'h12345678));
        vecs.push_back(mk("lb",      1, 4'd1, 5'd11, 1, 32'h0,        32'h20,       32'h0,        0, 1, 2, 5'd11, 1, 32'hFFFFFF80));
        vecs.push_back(mk("lbu",     1, 4'd4, 5'd12, 1, 32'h0,        32'h20,       32'h0,        0, 1, 2, 5'd12, 1, 32'h00000080));
        vecs.push_back(mk("sh_wait", 1, 4'd7, 5'd13, 1, 32'h0,        32'h42,       32'h0000ABCD, 3, 1, 9, 5'd0,  0, 32'h0));
        vecs.push_back(mk("lhu",     1, 4'd5, 5'd14, 1, 32'h0,        32'h42,       32'h0,        0, 1, 3, 5'd14, 1, 32'h0000ABCD));
        vecs.push_back(mk("lh",      1, 4'd2, 5'd15, 1, 32'h0,        32'h42,       32'h0,        0, 1, 3, 5'd15, 1, 32'hFFFFABCD));
        vecs.push_back(mk("op12",    1, 4'd12,5'd3,  1, 32'hDEAD,     32'h42,       32'h0,        0, 0, 1, 5'd3,  1, 32'hDEAD));
        vecs.push_back(mk("bubble",  0, 4'd3, 5'd9,  1, 32'h55,       32'h100,      32'h0,        0, 0, 1, 5'd0,  0, 32'h0));
        vecs.push_back(mk("sw",      1, 4'd8, 5'd7,  1, 32'h0,        32'h1FC,      32'h11223344, 0, 1, 5, 5'd0,  0, 32'h0));
        vecs.push_back(mk("lw_wait", 1, 4'd3, 5'd8,  1, 32'h0,        32'h1FC,      32'h0,        1, 1, 9, 5'd8,  1, 32'h11223344));
        vecs.push_back(mk("alu_nowr",1, 4'd0, 5'd6,  0, 32'h1234,     32'h0,        32'h0,        0, 0, 1, 5'd6,  0, 32'h0));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk("lw_mis",  1, 4'd3, 5'd20, 1, 32'h0,        32'h101,      32'h0,        0, 0, 1, 5'd0,  0, 32'h0));
        vecs.push_back(mk("sh_mis",  1, 4'd7, 5'd21, 1, 32'h0,        32'hFFFFFFFF, 32'h00005AA5, 0, 0, 1, 5'd0,  0, 32'h0));
        vecs.push_back(mk("lbu_top", 1, 4'd4, 5'd22, 1, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 1, 2, 5'd22, 1, 32'h0));
`else
        vecs.push_back(mk("lw_mis",  1, 4'd3, 5'd20, 1, 32'h0,        32'h101,      32'h0,        0, 1, 5, 5'd20, 1, 32'h9A123456));
        vecs.push_back(mk("sh_wrap", 1, 4'd7, 5'd21, 1, 32'h0,        32'hFFFFFFFF, 32'h00005AA5, 0, 1, 3, 5'd0,  0, 32'h0));
        vecs.push_back(mk("lhu_wrap",1, 4'd5, 5'd22, 1, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 1, 3, 5'd22, 1, 32'h00005AA5));
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/wd", 32'(wd_o), 32'd0);
        check("reset/wreg", 32'(wreg_o), 32'd0);
        check("reset/wdata", wdata_o, 32'd0);
        check("reset/req", 32'(mem_req_o), 32'd0);
        check("reset/we", 32'(mem_we_o), 32'd0);
        check("reset/a", mem_a_o, 32'd0);
        check("reset/dout", 32'(mem_dout_o), 32'd0);
        check("reset/stall", 32'(stall_req_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run(vecs[i]);

        // Reset in the middle of a word load, after two bytes were acked.
        valid_i = 1'b1; mem_op_i = 4'd3; wd_i = 5'd10; wreg_i = 1'b1;
        mem_addr_i = 32'h100; mem_sdata_i = 32'h0;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("rst_mid/stall0", 32'(stall_req_o), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_mid/req", 32'(mem_req_o), 32'd1);
            check("rst_mid/a", mem_a_o, 32'h100 + 32'(k));
            mem_ack_i = 1'b1;
            mem_din_i = mem_model[mem_a_o];
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("rst_mid/a2", mem_a_o, 32'h102);
        rst = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid/req_after", 32'(mem_req_o), 32'd0);
        check("rst_mid/stall_after", 32'(stall_req_o), 32'd0);
        check("rst_mid/wreg_after", 32'(wreg_o), 32'd0);
        check("rst_mid/wd_after", 32'(wd_o), 32'd0);
        check("rst_mid/a_after", mem_a_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // A full word load after the aborted one must start from byte 0 again.
        run(mk("lw_after_rst", 1, 4'd3, 5'd17, 1, 32'h0, 32'h100, 32'h0, 0, 1, 5, 5'd17, 1, 32'h12345678));
        run(mk("alu_after_rst", 1, 4'd0, 5'd4, 1, 32'hCAFE, 32'h0, 32'h0, 0, 0, 1, 5'd4, 1, 32'hCAFE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
